zap_wb_arb: RTL and testbench

- Wishbone master-side arbiter that registers and merges two `_nxt`-style requesters onto the single ZAP Wishbone master port.
- Requester 0 is the TLB page-table walker (`o_wb_*_nxt` from the TLB unit). Requester 1 is the cache line-fill/writeback FSM.
- Grants one owner per bus cycle and holds the grant until that owner drops CYC. Routes ACK/DAT back to the owner only.
- Replaces the current OR-gate merging with registered, exclusive ownership.

---
 rtl/zap_wb_arb.sv | 140 ++++++++++++++
 tb/tb_zap_wb_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_arb.sv
// Registers and arbitrates the TLB walker and cache fill FSM onto the single ZAP Wishbone master port.
// One register stage of latency; the grant is held until its owner drops CYC, and a waiting requester sees no ACK.
module zap_wb_arb #(
  parameter bit          TLB_PRIORITY   = 1'b1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_tlb_wb_cyc_nxt,
  input  logic        i_tlb_wb_stb_nxt,
  input  logic [31:0] i_tlb_wb_adr_nxt,
  input  logic        i_tlb_wb_wen_nxt,
  input  logic [3:0]  i_tlb_wb_sel_nxt,
  input  logic [31:0] i_tlb_wb_dat_nxt,
  output logic        o_tlb_wb_ack,
  output logic [31:0] o_tlb_wb_dat,

  input  logic        i_cache_wb_cyc_nxt,
  input  logic        i_cache_wb_stb_nxt,
  input  logic [31:0] i_cache_wb_adr_nxt,
  input  logic        i_cache_wb_wen_nxt,
  input  logic [3:0]  i_cache_wb_sel_nxt,
  input  logic [31:0] i_cache_wb_dat_nxt,
  output logic        o_cache_wb_ack,
  output logic [31:0] o_cache_wb_dat,

  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,

  output logic [1:0]  o_owner,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_TLB   = 2'b01;
  localparam logic [1:0] S_CACHE = 2'b10;

  logic [1:0]  state;
  logic [31:0] wd_cnt;
  logic        grant_tlb;
  logic        grant_cache;
  logic        use_tlb;
  logic        load;
  logic        nxt_cyc;
  logic        nxt_stb;
  logic [31:0] nxt_adr;
  logic        nxt_we;
  logic [3:0]  nxt_sel;
  logic [31:0] nxt_dat;

  assign grant_tlb   = i_tlb_wb_cyc_nxt & (~i_cache_wb_cyc_nxt | TLB_PRIORITY);
  assign grant_cache = i_cache_wb_cyc_nxt & ~grant_tlb;

  // Only the current owner's fields (or the winner from IDLE) ever reach the bus.
  always_comb begin
    use_tlb = (state == S_TLB) || ((state == S_IDLE) && grant_tlb);
    load    = (state != S_IDLE) || grant_tlb || grant_cache;
    if (use_tlb) begin
      nxt_cyc = i_tlb_wb_cyc_nxt;
      nxt_stb = i_tlb_wb_stb_nxt;
      nxt_adr = i_tlb_wb_adr_nxt;
      nxt_we  = i_tlb_wb_wen_nxt;
      nxt_sel = i_tlb_wb_sel_nxt;
      nxt_dat = i_tlb_wb_dat_nxt;
    end else begin
      nxt_cyc = i_cache_wb_cyc_nxt;
      nxt_stb = i_cache_wb_stb_nxt;
      nxt_adr = i_cache_wb_adr_nxt;
      nxt_we  = i_cache_wb_wen_nxt;
      nxt_sel = i_cache_wb_sel_nxt;
      nxt_dat = i_cache_wb_dat_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_adr <= '0;
      o_wb_we  <= 1'b0;
      o_wb_sel <= '0;
      o_wb_dat <= '0;
    end else begin
      if (load) begin
        o_wb_cyc <= nxt_cyc;
        o_wb_stb <= nxt_stb & nxt_cyc;
        o_wb_adr <= nxt_adr;
        o_wb_we  <= nxt_we;
        o_wb_sel <= nxt_sel;
        o_wb_dat <= nxt_dat;
      end else begin
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_wb_adr <= '0;
        o_wb_we  <= 1'b0;
        o_wb_sel <= '0;
        o_wb_dat <= '0;
      end
      // Releasing always passes through IDLE, which guarantees a CYC-low gap.
      case (state)
        S_IDLE:  state <= grant_tlb ? S_TLB : (grant_cache ? S_CACHE : S_IDLE);
        S_TLB:   if (!i_tlb_wb_cyc_nxt) state <= S_IDLE;
        S_CACHE: if (!i_cache_wb_cyc_nxt) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || (TIMEOUT_CYCLES == 32'd0)) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if ((state == S_IDLE) || !o_wb_stb || i_wb_ack) begin
        wd_cnt <= '0;
      end else if (wd_cnt == (TIMEOUT_CYCLES - 32'd1)) begin
        o_timeout <= 1'b1;
        wd_cnt    <= '0;
      end else begin
        wd_cnt <= wd_cnt + 32'd1;
      end
    end
  end

  assign o_owner        = state;
  assign o_tlb_wb_ack   = i_wb_ack & (state == S_TLB) & o_wb_stb & ~i_reset;
  assign o_cache_wb_ack = i_wb_ack & (state == S_CACHE) & o_wb_stb & ~i_reset;
  assign o_tlb_wb_dat   = (state == S_TLB) ? i_wb_dat : '0;
  assign o_cache_wb_dat = (state == S_CACHE) ? i_wb_dat : '0;

endmodule

// File: tb/tb_zap_wb_arb.sv
// Scoreboard bench for zap_wb_arb: stimulus queues expected bus beats, ACK routes, state snapshots and timeout pulses.
module tb_zap_wb_arb;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        tc, ts, tw, cc, cs, cw;
  logic [31:0] ta, td, ca, cd;
  logic [3:0]  tsel, csel;
  logic        o_tlb_wb_ack, o_cache_wb_ack;
  logic [31:0] o_tlb_wb_dat, o_cache_wb_dat;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic [31:0] i_wb_dat;
  logic [1:0]  o_owner;
  logic        o_timeout;

  always #5 clk = ~clk;

  zap_wb_arb #(.TLB_PRIORITY(1'b1), .TIMEOUT_CYCLES(32'd8)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_tlb_wb_cyc_nxt(tc), .i_tlb_wb_stb_nxt(ts), .i_tlb_wb_adr_nxt(ta),
    .i_tlb_wb_wen_nxt(tw), .i_tlb_wb_sel_nxt(tsel), .i_tlb_wb_dat_nxt(td),
    .o_tlb_wb_ack(o_tlb_wb_ack), .o_tlb_wb_dat(o_tlb_wb_dat),
    .i_cache_wb_cyc_nxt(cc), .i_cache_wb_stb_nxt(cs), .i_cache_wb_adr_nxt(ca),
    .i_cache_wb_wen_nxt(cw), .i_cache_wb_sel_nxt(csel), .i_cache_wb_dat_nxt(cd),
    .o_cache_wb_ack(o_cache_wb_ack), .o_cache_wb_dat(o_cache_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_adr(o_wb_adr), .o_wb_we(o_wb_we),
    .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat),
    .o_owner(o_owner), .o_timeout(o_timeout)
  );

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic        tack;
    logic        cack;
    logic [31:0] tdat;
    logic [31:0] cdat;
  } ack_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        wcyc;
    logic        wstb;
    logic [1:0]  own;
    logic        tack;
    logic        cack;
  } st_t;

  bus_t bus_q[$];
  ack_t ack_q[$];
  st_t  st_q[$];
  int   to_q[$];
  int   cyc_no = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   fin = 1'b0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tlb(input logic c, input logic s, input logic [31:0] a,
                         input logic w, input logic [3:0] sl, input logic [31:0] d);
    tc = c; ts = s; ta = a; tw = w; tsel = sl; td = d;
  endtask

  task automatic set_cache(input logic c, input logic s, input logic [31:0] a,
                           input logic w, input logic [3:0] sl, input logic [31:0] d);
    cc = c; cs = s; ca = a; cw = w; csel = sl; cd = d;
  endtask

  task automatic exp_bus(input logic [1:0] own, input logic [31:0] a, input logic w,
                         input logic [3:0] sl, input logic [31:0] d);
    bus_q.push_back('{own: own, adr: a, we: w, sel: sl, dat: d});
  endtask

  task automatic exp_ack(input logic t, input logic c, input logic [31:0] tdd, input logic [31:0] cdd);
    ack_q.push_back('{tack: t, cack: c, tdat: tdd, cdat: cdd});
  endtask

  task automatic exp_st(input logic wc, input logic ws, input logic [1:0] own,
                        input logic t, input logic c);
    st_q.push_back('{cyc: cyc_no, wcyc: wc, wstb: ws, own: own, tack: t, cack: c});
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc_no);
    end
  endtask

  // Monitor: the only process that compares or touches the counters.
  always @(negedge clk) begin
    if (!fin) begin
      if (o_wb_stb) begin
        if (bus_q.size() == 0) chk("bus_unexpected_stb", 64'd1, 64'd0);
        else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_adr", {32'd0, o_wb_adr}, {32'd0, b.adr});
          chk("bus_cyc_own_we_sel", {56'd0, o_wb_cyc, o_owner, o_wb_we, o_wb_sel},
              {56'd0, 1'b1, b.own, b.we, b.sel});
          chk("bus_dat", {32'd0, o_wb_dat}, {32'd0, b.dat});
        end
      end
      if (o_tlb_wb_ack || o_cache_wb_ack) begin
        if (ack_q.size() == 0) chk("ack_unexpected", {62'd0, o_tlb_wb_ack, o_cache_wb_ack}, 64'd0);
        else begin
          ack_t k;
          k = ack_q.pop_front();
          chk("ack_route", {62'd0, o_tlb_wb_ack, o_cache_wb_ack}, {62'd0, k.tack, k.cack});
          chk("ack_data", {o_tlb_wb_dat, o_cache_wb_dat}, {k.tdat, k.cdat});
        end
      end
      if (o_timeout) begin
        if (to_q.size() == 0) chk("timeout_unexpected", 64'(cyc_no), 64'd0);
        else chk("timeout_cycle", 64'(cyc_no), 64'(to_q.pop_front()));
      end
      while (st_q.size() > 0 && int'(st_q[0].cyc) <= cyc_no) begin
        st_t s;
        s = st_q.pop_front();
        chk("state_snapshot", {58'd0, o_wb_cyc, o_wb_stb, o_owner, o_tlb_wb_ack, o_cache_wb_ack},
            {58'd0, s.wcyc, s.wstb, s.own, s.tack, s.cack});
      end
      if (done) begin
        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        chk("timeout_q_drained", 64'(to_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        fin = 1'b1;
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_wb_ack = 1'b0; i_wb_dat = '0;
    set_tlb(0, 0, 0, 0, 0, 0);
    set_cache(0, 0, 0, 0, 0, 0);
    tick(); tick();
    exp_st(0, 0, 2'b00, 0, 0);
    i_reset = 1'b0;
    tick();
    // Spurious ACK while idle must not reach either requester.
    i_wb_ack = 1'b1; i_wb_dat = 32'hBAD0_0001;
    exp_st(0, 0, 2'b00, 0, 0);
    tick();
    i_wb_ack = 1'b0;

    // TLB single read.
    set_tlb(1, 1, 32'h0000_4000, 0, 4'hF, 0);
    exp_bus(2'b01, 32'h0000_4000, 0, 4'hF, 0);
    tick();
    i_wb_ack = 1'b1; i_wb_dat = 32'hDEAD_BEEF;
    exp_st(1, 1, 2'b01, 1, 0);
    exp_ack(1, 0, 32'hDEAD_BEEF, 0);
    set_tlb(0, 0, 0, 0, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    exp_st(0, 0, 2'b00, 0, 0);
    tick();

    // Contention: TLB wins, one idle cycle, then cache.
    set_tlb(1, 1, 32'h0000_2000, 0, 4'hF, 0);
    set_cache(1, 1, 32'h1000_0020, 0, 4'hF, 0);
    exp_bus(2'b01, 32'h0000_2000, 0, 4'hF, 0);
    tick();
    i_wb_ack = 1'b1; i_wb_dat = 32'h1111_1111;
    exp_st(1, 1, 2'b01, 1, 0);
    exp_ack(1, 0, 32'h1111_1111, 0);
    set_tlb(0, 0, 0, 0, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    exp_st(0, 0, 2'b00, 0, 0);
    exp_bus(2'b10, 32'h1000_0020, 0, 4'hF, 0);
    tick();
    i_wb_ack = 1'b1; i_wb_dat = 32'h2222_2222;
    exp_st(1, 1, 2'b10, 0, 1);
    exp_ack(0, 1, 0, 32'h2222_2222);
    set_cache(0, 0, 0, 0, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    exp_st(0, 0, 2'b00, 0, 0);
    tick();

    // Cache 4-beat burst write with a TLB request arriving mid-burst.
    set_cache(1, 1, 32'h0000_0100, 1, 4'hF, 32'hC0DE_0000);
    exp_bus(2'b10, 32'h0000_0100, 1, 4'hF, 32'hC0DE_0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      i_wb_ack = 1'b1; i_wb_dat = 32'hA5A5_0000 + 32'(i);
      exp_ack(0, 1, 0, 32'hA5A5_0000 + 32'(i));
      exp_st(1, 1, 2'b10, 0, 1);
      if (i == 1) set_tlb(1, 1, 32'h0000_3000, 0, 4'h3, 0);
      if (i < 3) begin
        set_cache(1, 1, 32'h0000_0100 + 32'(4 * (i + 1)), 1, 4'hF, 32'hC0DE_0000 + 32'(i + 1));
        exp_bus(2'b10, 32'h0000_0100 + 32'(4 * (i + 1)), 1, 4'hF, 32'hC0DE_0000 + 32'(i + 1));
      end else begin
        set_cache(0, 0, 0, 0, 0, 0);
      end
      tick();
    end
    i_wb_ack = 1'b0;
    exp_st(0, 0, 2'b00, 0, 0);
    exp_bus(2'b01, 32'h0000_3000, 0, 4'h3, 0);
    tick();
    i_wb_ack = 1'b1; i_wb_dat = 32'h3333_3333;
    exp_st(1, 1, 2'b01, 1, 0);
    exp_ack(1, 0, 32'h3333_3333, 0);
    set_tlb(0, 0, 0, 0, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    exp_st(0, 0, 2'b00, 0, 0);
    tick();

    // Watchdog: STB held without ACK pulses o_timeout 8 edges after STB rises.
    set_tlb(1, 1, 32'h0000_5000, 0, 4'hF, 0);
    for (int k = 0; k < 12; k++) begin
      exp_bus(2'b01, 32'h0000_5000, 0, 4'hF, 0);
      tick();
      if (k == 0) to_q.push_back(cyc_no + 8);
    end
    i_wb_ack = 1'b1; i_wb_dat = 32'h5555_5555;
    exp_ack(1, 0, 32'h5555_5555, 0);
    set_tlb(0, 0, 0, 0, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    tick();

    // Watchdog: ACK on the last counting cycle suppresses the pulse.
    set_tlb(1, 1, 32'h0000_6000, 0, 4'hF, 0);
    for (int k = 0; k < 12; k++) begin
      exp_bus(2'b01, 32'h0000_6000, 0, 4'hF, 0);
      tick();
      if (k == 7) begin
        i_wb_ack = 1'b1; i_wb_dat = 32'h7777_7777;
        exp_ack(1, 0, 32'h7777_7777, 0);
      end else begin
        i_wb_ack = 1'b0;
      end
    end
    i_wb_ack = 1'b1; i_wb_dat = 32'h6666_6666;
    exp_ack(1, 0, 32'h6666_6666, 0);
    set_tlb(0, 0, 0, 0, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    tick();

    // Reset mid-transfer while the cache owns the bus.
    set_cache(1, 1, 32'h0000_0600, 0, 4'hF, 0);
    exp_bus(2'b10, 32'h0000_0600, 0, 4'hF, 0);
    tick();
    i_reset = 1'b1; i_wb_ack = 1'b1; i_wb_dat = 32'h9999_9999;
    exp_st(1, 1, 2'b10, 0, 0);
    tick();
    exp_st(0, 0, 2'b00, 0, 0);
    i_reset = 1'b0;
    set_cache(0, 0, 0, 0, 0, 0);
    tick();
    exp_st(0, 0, 2'b00, 0, 0);
    tick();
    i_wb_ack = 1'b0;
    tick();
    done = 1'b1;
    tick();
    tick();
  end

endmodule
